// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: self-timed 2..4 direction light sequencer
// with tick prescaler, PWM dimming, walk phase and flash mode.
module traffic_phase_ctrl #(
  parameter int NUM_DIRS        = 2,
  parameter int TICK_DIV        = 10_000_000,
  parameter int GREEN_TICKS     = 40,
  parameter int YELLOW_TICKS    = 8,
  parameter int ALLRED_TICKS    = 2,
  parameter int MIN_GREEN_TICKS = 10,
  parameter int WALK_TICKS      = 30,
  parameter int PWM_BITS        = 3,
  parameter int DUTY_ON         = 2,
  parameter int DUTY_DIM        = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ped_req,
  input  logic                flash_en,
  output logic [NUM_DIRS-1:0] green,
  output logic [NUM_DIRS-1:0] red,
  output logic                walk,
  output logic [2:0]          phase,
  output logic [1:0]          dir
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_GREEN  = 3'd0,
    S_YELLOW = 3'd1,
    S_ALLRED = 3'd2,
    S_WALK   = 3'd3,
    S_FLASH  = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [PW-1:0]       presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [7:0]          timer, timer_n, dur_last;
  logic [1:0]          dir_q, dir_n, dir_inc;
  logic                ped_pend, ped_n;
  logic                toggle, tog_n;
  logic                fresh, fresh_n;
  logic                tick, pwm_on, pwm_dim, to_green;
  logic [NUM_DIRS-1:0] sel, on_v, dim_v;
  logic [NUM_DIRS-1:0] green_d, red_d;
  logic                walk_d;

  assign tick    = (presc == PW'(TICK_DIV - 1));
  assign pwm_on  = (int'(pwm_cnt) < DUTY_ON);
  assign pwm_dim = (int'(pwm_cnt) < DUTY_DIM);
  assign on_v    = {NUM_DIRS{pwm_on}};
  assign dim_v   = {NUM_DIRS{pwm_dim}};
  assign dir_inc = (dir_q == 2'(NUM_DIRS - 1)) ? 2'd0 : dir_q + 2'd1;

  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_DIRS; k++)
      sel[k] = (dir_q == 2'(k));
  end

  always_comb begin
    unique case (state)
      S_GREEN:  dur_last = 8'(GREEN_TICKS - 1);
      S_YELLOW: dur_last = 8'(YELLOW_TICKS - 1);
      S_WALK:   dur_last = 8'(WALK_TICKS - 1);
      default:  dur_last = 8'(ALLRED_TICKS - 1);
    endcase
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    dir_n    = dir_q;
    ped_n    = ped_pend;
    tog_n    = toggle;
    fresh_n  = fresh;
    to_green = 1'b0;
    if (flash_en) begin
      if (state != S_FLASH) begin
        state_n = S_FLASH;
        timer_n = '0;
        ped_n   = 1'b0;
        tog_n   = 1'b0;
      end else if (tick) begin
        if (timer == 8'd4) begin
          timer_n = '0;
          tog_n   = ~toggle;
        end else begin
          timer_n = timer + 8'd1;
        end
      end
    end else if (state == S_FLASH) begin
      state_n = S_ALLRED;
      timer_n = '0;
    end else begin
      if (ped_req && state != S_WALK)
        ped_n = 1'b1;
      if (tick) begin
        timer_n = timer + 8'd1;
        if (timer == dur_last) begin
          timer_n = '0;
          unique case (state)
            S_GREEN:  state_n = S_YELLOW;
            S_YELLOW: state_n = S_ALLRED;
            S_ALLRED: begin
              if (ped_pend) begin
                state_n = S_WALK;
                ped_n   = 1'b0;
              end else begin
                to_green = 1'b1;
              end
            end
            S_WALK:   to_green = 1'b1;
            default:  ;
          endcase
        end else if (state == S_GREEN && ped_pend &&
                     timer >= 8'(MIN_GREEN_TICKS - 1)) begin
          state_n = S_YELLOW;
          timer_n = '0;
        end
      end
    end
    // the very first green after reset serves direction 0
    if (to_green) begin
      state_n = S_GREEN;
      if (fresh) fresh_n = 1'b0;
      else       dir_n   = dir_inc;
    end
  end

  always_comb begin
    green_d = '0;
    red_d   = '0;
    walk_d  = 1'b0;
    unique case (state)
      S_GREEN: begin
        green_d = sel & on_v;
        red_d   = ~sel & on_v;
      end
      S_YELLOW: begin
        green_d = sel & dim_v;
        red_d   = (sel & dim_v) | (~sel & on_v);
      end
      S_ALLRED: red_d = on_v;
      S_WALK: begin
        red_d  = on_v;
        walk_d = pwm_on;
      end
      S_FLASH: red_d = on_v & {NUM_DIRS{toggle}};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_ALLRED;
      presc    <= '0;
      pwm_cnt  <= '0;
      timer    <= '0;
      dir_q    <= '0;
      ped_pend <= 1'b0;
      toggle   <= 1'b0;
      fresh    <= 1'b1;
      green    <= '0;
      red      <= '0;
      walk     <= 1'b0;
      phase    <= 3'd2;
      dir      <= '0;
    end else begin
      state    <= state_n;
      presc    <= tick ? '0 : presc + PW'(1);
      pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
      timer    <= timer_n;
      dir_q    <= dir_n;
      ped_pend <= ped_n;
      toggle   <= tog_n;
      fresh    <= fresh_n;
      green    <= green_d;
      red      <= red_d;
      walk     <= walk_d;
      phase    <= state;
      dir      <= dir_q;
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: 2- and 3-direction sequencers driven together
// and checked cycle by cycle against a tick-level behavioural model.
module tb_traffic_phase_ctrl;

  localparam int TD = 4;
  localparam int MG = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_req = 1'b0;
  logic       flash_en = 1'b0;
  logic [1:0] g2, r2, d2, d3;
  logic [2:0] g3, r3, p2, p3;
  logic       w2, w3;

  traffic_phase_ctrl #(.NUM_DIRS(2), .TICK_DIV(TD), .PWM_BITS(3)) u_dut2 (
    .clk(clk), .rst(rst), .ped_req(ped_req), .flash_en(flash_en),
    .green(g2), .red(r2), .walk(w2), .phase(p2), .dir(d2)
  );

  traffic_phase_ctrl #(.NUM_DIRS(3), .TICK_DIV(TD), .PWM_BITS(3)) u_dut3 (
    .clk(clk), .rst(rst), .ped_req(ped_req), .flash_en(flash_en),
    .green(g3), .red(r3), .walk(w3), .phase(p3), .dir(d3)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d want %0d", tag, $time, got, exp);
    end
  endtask

  // model: ph 0 G,1 Y,2 AR,3 WALK,4 FLASH; el = ticks spent in phase
  int cyc;
  int m_n[2] = '{2, 3};
  int m_ph[2], m_d[2], m_el[2], m_ft[2];
  bit m_pend[2], m_fresh[2];
  int e_g[2], e_r[2], e_w[2], e_ph[2], e_d[2];

  function automatic int dur(input int ph);
    case (ph)
      0: return 40;
      1: return 8;
      3: return 30;
      default: return 2;
    endcase
  endfunction

  task automatic enter_green(input int i);
    m_ph[i] = 0;
    if (m_fresh[i]) m_fresh[i] = 0;
    else m_d[i] = (m_d[i] + 1) % m_n[i];
  endtask

  task automatic model_edge();
    int pwm, full, sel;
    bit on, dim, tk, p_old;
    pwm = cyc % 8;
    on  = (pwm < 2);
    dim = (pwm < 1);
    tk  = ((cyc % TD) == TD - 1);
    for (int i = 0; i < 2; i++) begin
      e_g[i] = 0; e_r[i] = 0; e_w[i] = 0;
      if (rst) begin
        e_ph[i] = 2; e_d[i] = 0;
        m_ph[i] = 2; m_d[i] = 0; m_el[i] = 0; m_ft[i] = 0;
        m_pend[i] = 0; m_fresh[i] = 1;
        continue;
      end
      full = (1 << m_n[i]) - 1;
      sel  = 1 << m_d[i];
      case (m_ph[i])
        0: begin
          e_g[i] = on ? sel : 0;
          e_r[i] = on ? (full & ~sel) : 0;
        end
        1: begin
          e_g[i] = dim ? sel : 0;
          e_r[i] = (on ? (full & ~sel) : 0) | (dim ? sel : 0);
        end
        3: begin
          e_r[i] = on ? full : 0;
          e_w[i] = int'(on);
        end
        4: e_r[i] = (on && ((m_ft[i] / 5) % 2 == 1)) ? full : 0;
        default: e_r[i] = on ? full : 0;
      endcase
      e_ph[i] = m_ph[i];
      e_d[i]  = m_d[i];
      p_old = m_pend[i];
      if (flash_en) begin
        if (m_ph[i] != 4) begin
          m_ph[i] = 4; m_ft[i] = 0; m_pend[i] = 0;
        end else if (tk) begin
          m_ft[i]++;
        end
      end else if (m_ph[i] == 4) begin
        m_ph[i] = 2; m_el[i] = 0;
      end else begin
        if (ped_req && m_ph[i] != 3) m_pend[i] = 1;
        if (tk) begin
          if (m_el[i] + 1 == dur(m_ph[i])) begin
            m_el[i] = 0;
            case (m_ph[i])
              0: m_ph[i] = 1;
              1: m_ph[i] = 2;
              2: begin
                if (p_old) begin m_ph[i] = 3; m_pend[i] = 0; end
                else enter_green(i);
              end
              default: enter_green(i);
            endcase
          end else if (m_ph[i] == 0 && p_old && m_el[i] >= MG - 1) begin
            m_ph[i] = 1; m_el[i] = 0;
          end else begin
            m_el[i]++;
          end
        end
      end
    end
    cyc = rst ? 0 : cyc + 1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("green2", 32'(g2), e_g[0]);
    check("red2",   32'(r2), e_r[0]);
    check("walk2",  32'(w2), e_w[0]);
    check("phase2", 32'(p2), e_ph[0]);
    check("dir2",   32'(d2), e_d[0]);
    check("green3", 32'(g3), e_g[1]);
    check("red3",   32'(r3), e_r[1]);
    check("walk3",  32'(w3), e_w[1]);
    check("phase3", 32'(p3), e_ph[1]);
    check("dir3",   32'(d3), e_d[1]);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ped_req = 1'b0;
    flash_en = 1'b0;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    cyc = 0;
    do_reset();
    check("rst_red2", 32'(r2), 0);
    check("rst_phase2", 32'(p2), 2);
    step();
    check("first_red2", 32'(r2), 3);
    check("first_red3", 32'(r3), 7);
    run(420);

    // request early in G0: cut at MIN_GREEN, then walk
    do_reset();
    run(21);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    run(500);

    // late request in G0, then a request during walk
    do_reset();
    run(89);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    run(60);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    run(400);

    // flash mid-yellow, then release
    do_reset();
    run(180);
    flash_en = 1'b1; run(120);
    flash_en = 1'b0; run(300);

    // reset in the middle of G1
    do_reset();
    run(230);
    rst = 1'b1; step();
    check("mid_rst_dir3", 32'(d3), 0);
    rst = 1'b0;
    run(300);

    do_reset();
    for (int k = 0; k < 6000; k++) begin
      ped_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) flash_en = ~flash_en;
      rst = ($urandom_range(0, 2999) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
